// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with io/mem/ext address decode and ext-window wait states.
// Optional macro BUS_ARB_ROUND_ROBIN_EN selects round-robin contention; default is fixed priority to master 0.
module bus_arbiter #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 16'h0000,
    parameter int                    IO_SIZE    = 64,
    parameter logic [ADDR_WIDTH-1:0] SRAM_BASE  = 16'h0040,
    parameter int                    SRAM_SIZE  = 128,
    parameter int                    EXT_WAIT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic                  bus_drive,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  io_cs,
    output logic                  io_we,
    output logic                  io_oe,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic                  ext_cs,
    output logic                  ext_we,
    output logic                  ext_oe
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {R_IO, R_MEM, R_EXT} region_t;

    localparam logic [ADDR_WIDTH:0] IO_LEN    = (ADDR_WIDTH+1)'(IO_SIZE);
    localparam logic [ADDR_WIDTH:0] SRAM_LEN  = (ADDR_WIDTH+1)'(SRAM_SIZE);
    localparam logic [3:0]          WAIT_INIT = 4'(EXT_WAIT - 1);
    localparam bit                  HAS_WAIT  = (EXT_WAIT > 0);

    // Offsets are one bit wider than the address: an address below a window's
    // base wraps to a value above any window size instead of aliasing into it.
    function automatic region_t decode(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] io_off;
        logic [ADDR_WIDTH:0] mem_off;
        io_off  = {1'b0, a} - {1'b0, IO_BASE};
        mem_off = {1'b0, a} - {1'b0, SRAM_BASE};
        if (io_off < IO_LEN)    return R_IO;
        if (mem_off < SRAM_LEN) return R_MEM;
        return R_EXT;
    endfunction

    state_t                state;
    region_t               region;
    logic                  owner;
    logic                  we_q;
    logic [3:0]            wait_cnt;
    logic                  xfer_end;

    logic                  pick;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    region_t               sel_region;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic                  last_gnt;
`endif

    // NOTE: pick gets a default before any conditional update so no latch is inferred.
    always_comb begin
        pick = m1_req & ~m0_req;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req) pick = ~last_gnt;
`endif
    end

    assign sel_we     = pick ? m1_we    : m0_we;
    assign sel_addr   = pick ? m1_addr  : m0_addr;
    assign sel_wdata  = pick ? m1_wdata : m0_wdata;
    assign sel_region = decode(sel_addr);

    assign xfer_end = (state == S_ACCESS && !(region == R_EXT && HAS_WAIT)) ||
                      (state == S_WAIT && wait_cnt == 4'd0);

    // NOTE: all state and outputs use non-blocking assignments; the xfer_end block
    // below overrides the per-state case because the last scheduled update wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            region    <= R_IO;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            wait_cnt  <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_drive <= 1'b0;
            {io_cs, io_we, io_oe}    <= 3'b000;
            {mem_cs, mem_we, mem_oe} <= 3'b000;
            {ext_cs, ext_we, ext_oe} <= 3'b000;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_gnt  <= 1'b0;
`endif
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        owner     <= pick;
                        we_q      <= sel_we;
                        region    <= sel_region;
                        m0_gnt    <= ~pick;
                        m1_gnt    <= pick;
                        bus_addr  <= sel_addr;
                        bus_wdata <= sel_wdata;
                        bus_drive <= sel_we;
                        io_cs     <= (sel_region == R_IO);
                        io_we     <= (sel_region == R_IO) & sel_we;
                        io_oe     <= (sel_region == R_IO) & ~sel_we;
                        mem_cs    <= (sel_region == R_MEM);
                        mem_we    <= (sel_region == R_MEM) & sel_we;
                        mem_oe    <= (sel_region == R_MEM) & ~sel_we;
                        ext_cs    <= (sel_region == R_EXT);
                        ext_we    <= (sel_region == R_EXT) & sel_we;
                        ext_oe    <= (sel_region == R_EXT) & ~sel_we;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (region == R_EXT && HAS_WAIT) begin
                        wait_cnt <= WAIT_INIT;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                end
                S_DONE: begin
                    m0_gnt   <= 1'b0;
                    m1_gnt   <= 1'b0;
                    m0_rdata <= '0;
                    m1_rdata <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                    last_gnt <= owner;
`endif
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (xfer_end) begin
                bus_drive <= 1'b0;
                {io_cs, io_we, io_oe}    <= 3'b000;
                {mem_cs, mem_we, mem_oe} <= 3'b000;
                {ext_cs, ext_we, ext_oe} <= 3'b000;
                m0_ack   <= ~owner;
                m1_ack   <= owner;
                m0_rdata <= (!owner && !we_q) ? bus_rdata : '0;
                m1_rdata <= (owner && !we_q) ? bus_rdata : '0;
                state    <= S_DONE;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed and random two-master traffic scored against a
// transaction-level arbitration model; read data checked through per-master queues.
module tb_bus_arbiter;

    localparam int EXT_WAIT  = 2;
    localparam int IO_BASE   = 0;
    localparam int IO_SIZE   = 64;
    localparam int SRAM_BASE = 64;
    localparam int SRAM_SIZE = 128;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [3:0]  gap;
    } stim_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req   = 2'b00;
    logic [1:0]  we    = 2'b00;
    logic [15:0] addr  [2];
    logic [7:0]  wdata [2];

    wire  [1:0]  gnt;
    wire  [1:0]  ack;
    wire  [7:0]  rdata0, rdata1;
    wire  [15:0] bus_addr;
    wire  [7:0]  bus_wdata;
    wire  [7:0]  bus_rdata;
    wire         bus_drive;
    wire         io_cs, io_we, io_oe, mem_cs, mem_we, mem_oe, ext_cs, ext_we, ext_oe;

    int          n_cmp = 0;
    int          n_bad = 0;

    stim_t       stim_q [2][$];
    logic [7:0]  exp_q  [2][$];
    int          ack_log [$];
    int          ack_cnt [2];

    bus_arbiter #(.EXT_WAIT(EXT_WAIT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(gnt[0]), .m0_ack(ack[0]), .m0_rdata(rdata0),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(gnt[1]), .m1_ack(ack[1]), .m1_rdata(rdata1),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_drive(bus_drive), .bus_rdata(bus_rdata),
        .io_cs(io_cs), .io_we(io_we), .io_oe(io_oe),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .ext_cs(ext_cs), .ext_we(ext_we), .ext_oe(ext_oe)
    );

    always #5 clk = ~clk;

    // Slave side: every window returns an address-derived byte while its oe is high.
    function automatic logic [7:0] rd_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h63;
    endfunction

    assign bus_rdata = (io_oe | mem_oe | ext_oe) ? rd_fn(bus_addr) : 8'hEE;

    function automatic int region_of(input logic [15:0] a);
        int v;
        v = int'(a);
        if (v >= IO_BASE && v < IO_BASE + IO_SIZE)     return 0;
        if (v >= SRAM_BASE && v < SRAM_BASE + SRAM_SIZE) return 1;
        return 2;
    endfunction

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return 16'($urandom_range(0, 63));
            1:       return 16'($urandom_range(64, 191));
            2:       return 16'($urandom_range(192, 65535));
            3:       return 16'h003F;
            4:       return 16'h0040;
            5:       return 16'h00BF;
            6:       return 16'h00C0;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic add(input int m, input logic w, input logic [15:0] a, input logic [7:0] d, input int gap);
        stim_t s;
        s.we = w; s.addr = a; s.wdata = d; s.gap = 4'(gap);
        stim_q[m].push_back(s);
    endtask

    // Master driver: holds req until ack, then either presents the next request
    // immediately (gap 0, so it is eligible in the following idle cycle) or drops req.
    task automatic drive(input int m);
        stim_t s;
        int    n;
        while (stim_q[m].size() > 0) begin
            s = stim_q[m].pop_front();
            repeat (int'(s.gap)) @(posedge clk);
            if (s.gap != 4'd0 || req[m] == 1'b0) #1;
            addr[m] = s.addr; we[m] = s.we; wdata[m] = s.wdata; req[m] = 1'b1;
            exp_q[m].push_back(s.we ? 8'h00 : rd_fn(s.addr));
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!ack[m] && n < 500);
            check("ack_seen", 32'(ack[m]), 32'd1);
            if (stim_q[m].size() == 0 || stim_q[m][0].gap != 4'd0) req[m] = 1'b0;
        end
        req[m] = 1'b0;
    endtask

    // Transaction-level model: the arbiter is free again the cycle after an ack;
    // a transfer decided in cycle k owns the bus for k+1..ack, ack = k+2(+EXT_WAIT for ext).
    int          cyc = 0;
    int          free_at = 0;
    bit          cur_valid = 1'b0;
    int          cur_w = 0, cur_start = 0, cur_ack = 0, cur_reg = 0;
    logic        cur_we = 1'b0;
    logic [7:0]  cur_wdata = '0;
    logic [15:0] m_bus_addr = '0;
    int          m_last = 0;

    always @(negedge clk) begin : monitor
        logic [13:0] act_c;
        logic [13:0] want_c;
        int          base;
        cyc++;
        if (!reset) begin
            cur_valid  = 1'b0;
            m_last     = 0;
            m_bus_addr = '0;
            free_at    = cyc + 1;
        end

        want_c = '0;
        if (cur_valid && cyc > cur_start && cyc <= cur_ack) begin
            want_c[12 + cur_w] = 1'b1;
            if (cyc == cur_ack) begin
                want_c[10 + cur_w] = 1'b1;
            end else begin
                base = 9 - 3 * cur_reg;
                want_c[base]     = 1'b1;
                want_c[base - 1] = cur_we;
                want_c[base - 2] = ~cur_we;
                want_c[0]        = cur_we;
                if (cur_we) check("bus_wdata", 32'(bus_wdata), 32'(cur_wdata));
            end
        end
        act_c = {gnt[1], gnt[0], ack[1], ack[0], io_cs, io_we, io_oe,
                 mem_cs, mem_we, mem_oe, ext_cs, ext_we, ext_oe, bus_drive};
        check("ctrl_strobes", 32'(act_c), 32'(want_c));
        check("bus_addr", 32'(bus_addr), 32'(m_bus_addr));

        for (int m = 0; m < 2; m++) begin
            if (ack[m]) begin
                ack_cnt[m]++;
                ack_log.push_back(m);
                if (exp_q[m].size() == 0) check("unexpected_ack", 32'(ack[m]), 32'd0);
                else check("rdata", 32'(m == 1 ? rdata1 : rdata0), 32'(exp_q[m].pop_front()));
            end
        end

        if (reset && cyc >= free_at && req != 2'b00) begin
            if (req == 2'b11) cur_w = RR ? (1 - m_last) : 0;
            else              cur_w = req[1] ? 1 : 0;
            cur_reg    = region_of(addr[cur_w]);
            cur_we     = we[cur_w];
            cur_wdata  = wdata[cur_w];
            cur_start  = cyc;
            cur_ack    = cyc + 2 + (cur_reg == 2 ? EXT_WAIT : 0);
            free_at    = cur_ack + 1;
            m_last     = cur_w;
            m_bus_addr = addr[cur_w];
            cur_valid  = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [6];
        int n0, n1;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        ack_cnt[0] = 0; ack_cnt[1] = 0;

        #1 reset = 1'b0;
        #2;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_bus_addr", 32'(bus_addr), 32'd0);
        check("reset_strobes", 32'({io_cs, io_we, io_oe, mem_cs, mem_we, mem_oe,
                                     ext_cs, ext_we, ext_oe, bus_drive}), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Uncontended transfers across every window edge; m1 finishes last.
        add(0, 1'b1, 16'h0045, 8'hA5, 1);
        add(0, 1'b0, 16'h1000, 8'h00, 1);
        add(0, 1'b0, 16'h0040, 8'h00, 1);
        add(0, 1'b1, 16'h00BF, 8'h3C, 1);
        add(0, 1'b0, 16'h00C0, 8'h00, 1);
        add(0, 1'b1, 16'hFFFF, 8'h81, 1);
        drive(0);
        add(1, 1'b0, 16'h003F, 8'h00, 1);
        drive(1);
        repeat (3) @(posedge clk);

        // Simultaneous requests, three back-to-back transfers each.
        ack_log.delete();
        for (int i = 0; i < 3; i++) begin
            add(0, 1'b0, 16'(16'h0050 + i), 8'h00, 0);
            add(1, 1'b1, 16'(16'h0010 + i), 8'(8'h70 + i), 0);
        end
        if (RR) exp_order = '{0, 1, 0, 1, 0, 1};
        else    exp_order = '{0, 0, 0, 1, 1, 1};
        fork
            drive(0);
            drive(1);
        join
        repeat (2) @(posedge clk);
        check("order_len", 32'(ack_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < ack_log.size(); i++)
            check("arb_order", 32'(ack_log[i]), 32'(exp_order[i]));

        // Random traffic on both masters.
        for (int i = 0; i < 40; i++)
            for (int m = 0; m < 2; m++)
                add(m, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), $urandom_range(0, 3));
        fork
            drive(0);
            drive(1);
        join
        repeat (4) @(posedge clk);

        // m1 drops req (and changes addr) during ACCESS: exactly one ack, no re-grant.
        #1;
        n1 = ack_cnt[1];
        addr[1] = 16'h0050; we[1] = 1'b0; req[1] = 1'b1;
        exp_q[1].push_back(rd_fn(16'h0050));
        @(posedge clk); #1;
        req[1] = 1'b0; addr[1] = 16'h2000;
        repeat (8) @(posedge clk);
        check("drop_ack_count", 32'(ack_cnt[1] - n1), 32'd1);

        // Reset asserted while an ext read is in WAIT: outputs clear at once, no ack later.
        #1;
        n0 = ack_cnt[0];
        addr[0] = 16'h1000; we[0] = 1'b0; req[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_strobes", 32'({io_cs, io_we, io_oe, mem_cs, mem_we, mem_oe,
                                     ext_cs, ext_we, ext_oe, bus_drive}), 32'd0);
        req[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) @(posedge clk);
        check("abort_no_ack", 32'(ack_cnt[0] - n0), 32'd0);

        check("m0_queue_drained", 32'(exp_q[0].size()), 32'd0);
        check("m1_queue_drained", 32'(exp_q[1].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
